rv32_alu_arbiter: RTL and testbench

Shares one combinational RV32 ALU datapath between two requesters: port 0 is the integer execute stage and port 1 is the address/CSR helper. Each port has a valid/ready request channel and a valid/ready response channel with one registered result slot per port. Arbitration is round-robin, with fixed-priority fallback. Results return with 1-cycle latency. A saturating counter reports arbitration conflicts.

---
 rtl/rv32_alu_arbiter_if.sv | 21 ++
 rtl/rv32_alu_arbiter.sv | 99 +++++++++
 tb/tb_rv32_alu_arbiter.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/rv32_alu_arbiter_if.sv
// rtl/rv32_alu_arbiter_if.sv - request/response channel of one ALU requester port
interface rv32_alu_arbiter_if;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] op_1;
  logic [31:0] op_2;
  logic [3:0]  opcode;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_data;

  modport master (
    output req_valid, op_1, op_2, opcode, rsp_ready,
    input  req_ready, rsp_valid, rsp_data
  );

  modport slave (
    input  req_valid, op_1, op_2, opcode, rsp_ready,
    output req_ready, rsp_valid, rsp_data
  );
endinterface

// File: rtl/rv32_alu_arbiter.sv
// rtl/rv32_alu_arbiter.sv - two requesters share one combinational RV32 ALU
// Round-robin or fixed-priority grant, one registered result slot per port.
module rv32_alu_arbiter #(
  parameter bit RR_ENABLE = 1'b1,
  parameter int CNT_W     = 16
) (
  input  logic              clk_in,
  input  logic              rst_in,
  rv32_alu_arbiter_if.slave port_0,
  rv32_alu_arbiter_if.slave port_1,
  output logic [CNT_W-1:0]  conflict_cnt_out
);
  logic             last_grant;
  logic             slot_free_0, slot_free_1;
  logic             eligible_0, eligible_1;
  logic             grant_0, grant_1;
  logic             rsp_valid_0, rsp_valid_1;
  logic [31:0]      rsp_data_0, rsp_data_1;
  logic [31:0]      alu_a, alu_b, alu_result;
  logic [3:0]       alu_op;
  logic [4:0]       shamt;
  logic [CNT_W-1:0] conflict_cnt;

  // A slot being drained this cycle can take a new result immediately.
  assign slot_free_0 = !rsp_valid_0 || port_0.rsp_ready;
  assign slot_free_1 = !rsp_valid_1 || port_1.rsp_ready;
  assign eligible_0  = !rst_in && port_0.req_valid && slot_free_0;
  assign eligible_1  = !rst_in && port_1.req_valid && slot_free_1;

  always_comb begin
    grant_0 = 1'b0;
    grant_1 = 1'b0;
    if (eligible_0 && eligible_1) begin
      if (RR_ENABLE && !last_grant) grant_1 = 1'b1;
      else                          grant_0 = 1'b1;
    end else begin
      grant_0 = eligible_0;
      grant_1 = eligible_1;
    end
  end

  assign alu_a  = grant_1 ? port_1.op_1   : port_0.op_1;
  assign alu_b  = grant_1 ? port_1.op_2   : port_0.op_2;
  assign alu_op = grant_1 ? port_1.opcode : port_0.opcode;
  assign shamt  = alu_b[4:0];

  always_comb begin
    alu_result = 32'h0;
    case (alu_op[2:0])
      3'b000:  alu_result = alu_op[3] ? alu_a - alu_b : alu_a + alu_b;
      3'b001:  alu_result = alu_a << shamt;
      3'b010:  alu_result = {31'b0, $signed(alu_a) < $signed(alu_b)};
      3'b011:  alu_result = {31'b0, alu_a < alu_b};
      3'b100:  alu_result = alu_a ^ alu_b;
      3'b101:  alu_result = alu_op[3] ? $unsigned($signed(alu_a) >>> shamt) : alu_a >> shamt;
      3'b110:  alu_result = alu_a | alu_b;
      default: alu_result = alu_a & alu_b;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      last_grant   <= 1'b1;
      rsp_valid_0  <= 1'b0;
      rsp_valid_1  <= 1'b0;
      rsp_data_0   <= 32'h0;
      rsp_data_1   <= 32'h0;
      conflict_cnt <= '0;
    end else begin
      if (grant_0)      last_grant <= 1'b0;
      else if (grant_1) last_grant <= 1'b1;

      if (grant_0) begin
        rsp_valid_0 <= 1'b1;
        rsp_data_0  <= alu_result;
      end else if (rsp_valid_0 && port_0.rsp_ready) begin
        rsp_valid_0 <= 1'b0;
      end

      if (grant_1) begin
        rsp_valid_1 <= 1'b1;
        rsp_data_1  <= alu_result;
      end else if (rsp_valid_1 && port_1.rsp_ready) begin
        rsp_valid_1 <= 1'b0;
      end

      if (eligible_0 && eligible_1 && (conflict_cnt != {CNT_W{1'b1}}))
        conflict_cnt <= conflict_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign port_0.req_ready = grant_0;
  assign port_1.req_ready = grant_1;
  assign port_0.rsp_valid = rsp_valid_0;
  assign port_1.rsp_valid = rsp_valid_1;
  assign port_0.rsp_data  = rsp_data_0;
  assign port_1.rsp_data  = rsp_data_1;
  assign conflict_cnt_out = conflict_cnt;
endmodule

// File: tb/tb_rv32_alu_arbiter.sv
// tb/tb_rv32_alu_arbiter.sv - scoreboard bench for rv32_alu_arbiter
// dut_a: round-robin, 16-bit counter; dut_b: fixed priority, 4-bit counter.
module tb_rv32_alu_arbiter;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sel_b = 1'b0;
  logic [1:0]  rv = 2'b00;
  logic [1:0]  rr = 2'b11;
  logic [31:0] op1 [2];
  logic [31:0] op2 [2];
  logic [3:0]  opc [2];
  logic [1:0]  req_ready, rsp_valid;
  logic [31:0] rsp_data [2];
  logic [31:0] cnt;
  logic [15:0] cnt_a;
  logic [3:0]  cnt_b;
  int          checks = 0;
  int          errors = 0;
  logic [31:0] q0 [$];
  logic [31:0] q1 [$];

  logic [31:0] va [12] = '{32'd7, 32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd1,
                           32'h80000000, 32'hF0F0F0F0, 32'hF0F0F0F0, 32'hF0F0F0F0, 32'd5, 32'd7};
  logic [31:0] vb [12] = '{32'd5, 32'd4, 32'd1, 32'd1, 32'd1, 32'd33,
                           32'd4, 32'hFF00FF00, 32'h0F0F0000, 32'hFF00FF00, 32'd3, 32'h22};
  logic [3:0]  vo [12] = '{4'b1000, 4'b1101, 4'b0010, 4'b0011, 4'b0000, 4'b0001,
                           4'b0101, 4'b0100, 4'b0110, 4'b1111, 4'b1010, 4'b1001};
  logic [31:0] vr [12] = '{32'h2, 32'hF8000000, 32'h1, 32'h0, 32'h0, 32'h2,
                           32'h08000000, 32'h0FF00FF0, 32'hFFFFF0F0, 32'hF000F000, 32'h0, 32'h1C};

  always #5 clk = ~clk;

  rv32_alu_arbiter_if ia0 ();
  rv32_alu_arbiter_if ia1 ();
  rv32_alu_arbiter_if ib0 ();
  rv32_alu_arbiter_if ib1 ();

  assign ia0.req_valid = !sel_b && rv[0];
  assign ia1.req_valid = !sel_b && rv[1];
  assign ib0.req_valid = sel_b && rv[0];
  assign ib1.req_valid = sel_b && rv[1];
  assign ia0.rsp_ready = sel_b || rr[0];
  assign ia1.rsp_ready = sel_b || rr[1];
  assign ib0.rsp_ready = !sel_b || rr[0];
  assign ib1.rsp_ready = !sel_b || rr[1];
  assign ia0.op_1 = op1[0];  assign ia0.op_2 = op2[0];  assign ia0.opcode = opc[0];
  assign ia1.op_1 = op1[1];  assign ia1.op_2 = op2[1];  assign ia1.opcode = opc[1];
  assign ib0.op_1 = op1[0];  assign ib0.op_2 = op2[0];  assign ib0.opcode = opc[0];
  assign ib1.op_1 = op1[1];  assign ib1.op_2 = op2[1];  assign ib1.opcode = opc[1];

  assign req_ready   = sel_b ? {ib1.req_ready, ib0.req_ready} : {ia1.req_ready, ia0.req_ready};
  assign rsp_valid   = sel_b ? {ib1.rsp_valid, ib0.rsp_valid} : {ia1.rsp_valid, ia0.rsp_valid};
  assign rsp_data[0] = sel_b ? ib0.rsp_data : ia0.rsp_data;
  assign rsp_data[1] = sel_b ? ib1.rsp_data : ia1.rsp_data;
  assign cnt         = sel_b ? {28'b0, cnt_b} : {16'b0, cnt_a};

  rv32_alu_arbiter #(.RR_ENABLE(1'b1), .CNT_W(16)) dut_a (
    .clk_in(clk), .rst_in(rst), .port_0(ia0), .port_1(ia1), .conflict_cnt_out(cnt_a)
  );

  rv32_alu_arbiter #(.RR_ENABLE(1'b0), .CNT_W(4)) dut_b (
    .clk_in(clk), .rst_in(rst), .port_0(ib0), .port_1(ib1), .conflict_cnt_out(cnt_b)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic set_op(input int p, input logic [31:0] a, input logic [31:0] b, input logic [3:0] o);
    op1[p] = a;
    op2[p] = b;
    opc[p] = o;
  endtask

  // Entered one step after a rising edge; checks the grant and books expected results.
  task automatic step(input logic [1:0] eg, input logic [31:0] e0, input logic [31:0] e1, input string name);
    @(negedge clk);
    check({name, "_grant"}, {30'b0, req_ready}, {30'b0, eg});
    if (rv[0] && req_ready[0]) q0.push_back(e0);
    if (rv[1] && req_ready[1]) q1.push_back(e1);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    rv = 2'b00;
    repeat (n) @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (rsp_valid[0] && rr[0]) begin
        if (q0.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL mon0_unexpected actual=%h required=none", rsp_data[0]);
        end else check("mon0_data", rsp_data[0], q0.pop_front());
      end
      if (rsp_valid[1] && rr[1]) begin
        if (q1.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL mon1_unexpected actual=%h required=none", rsp_data[1]);
        end else check("mon1_data", rsp_data[1], q1.pop_front());
      end
    end
  end

  initial begin
    int p;
    set_op(0, 32'h0, 32'h0, 4'h0);
    set_op(1, 32'h0, 32'h0, 4'h0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("rst_valid", {30'b0, rsp_valid}, 32'h0);
    check("rst_data0", rsp_data[0], 32'h0);
    check("rst_data1", rsp_data[1], 32'h0);
    check("rst_cnt", cnt, 32'h0);
    @(posedge clk);
    #1;

    for (int i = 0; i < 12; i++) begin
      p = i % 2;
      set_op(p, va[i], vb[i], vo[i]);
      rv[p] = 1'b1;
      step((p == 0) ? 2'b01 : 2'b10, vr[i], vr[i], "vec");
      rv = 2'b00;
      @(negedge clk);
      check("lat_valid", 32'(rsp_valid[p]), 32'h1);
      check("lat_data", rsp_data[p], vr[i]);
      @(posedge clk);
      #1;
    end
    check("cnt_no_conflict", cnt, 32'h0);

    set_op(0, 32'd10, 32'd20, 4'b0000);
    set_op(1, 32'd10, 32'd20, 4'b1000);
    rv = 2'b11;
    for (int i = 0; i < 4; i++)
      step((i % 2 == 0) ? 2'b01 : 2'b10, 32'd30, 32'hFFFFFFF6, "rr");
    rv = 2'b00;
    @(negedge clk);
    check("rr_cnt", cnt, 32'd4);
    @(posedge clk);
    #1;

    rr = 2'b10;
    set_op(0, 32'd1, 32'd2, 4'b0000);
    rv = 2'b01;
    step(2'b01, 32'd3, 32'd0, "bp_setup");
    set_op(0, 32'd100, 32'd1, 4'b0000);
    set_op(1, 32'd5, 32'd3, 4'b0100);
    rv = 2'b11;
    for (int i = 0; i < 3; i++) begin
      step(2'b10, 32'd0, 32'd6, "bp");
      check("bp_hold_data", rsp_data[0], 32'd3);
      check("bp_hold_valid", 32'(rsp_valid[0]), 32'h1);
    end
    rr = 2'b11;
    step(2'b01, 32'd101, 32'd6, "bp_release");
    rv = 2'b00;
    @(negedge clk);
    check("bp_new_valid", 32'(rsp_valid[0]), 32'h1);
    check("bp_new_data", rsp_data[0], 32'd101);
    check("bp_cnt", cnt, 32'd5);
    @(posedge clk);
    #1;

    rr = 2'b01;
    set_op(1, 32'd9, 32'd6, 4'b0100);
    rv = 2'b10;
    step(2'b10, 32'd0, 32'd15, "rst_setup");
    rst = 1'b1;
    rv = 2'b11;
    rr = 2'b11;
    q1.delete();
    @(negedge clk);
    check("rst_pending", 32'(rsp_valid[1]), 32'h1);
    check("rst_no_ready", {30'b0, req_ready}, 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    rv = 2'b00;
    @(negedge clk);
    check("rst_mid_valid1", 32'(rsp_valid[1]), 32'h0);
    check("rst_mid_data1", rsp_data[1], 32'h0);
    check("rst_mid_cnt", cnt, 32'h0);
    @(posedge clk);
    #1;
    set_op(0, 32'd10, 32'd20, 4'b0000);
    rv = 2'b11;
    step(2'b01, 32'd30, 32'd15, "post_rst");
    step(2'b10, 32'd30, 32'd15, "post_rst2");
    idle(3);
    check("qa0_empty", q0.size(), 32'h0);
    check("qa1_empty", q1.size(), 32'h0);

    sel_b = 1'b1;
    set_op(0, 32'd3, 32'd4, 4'b0000);
    set_op(1, 32'd3, 32'd4, 4'b1000);
    rv = 2'b11;
    for (int i = 0; i < 4; i++) step(2'b01, 32'd7, 32'hFFFFFFFF, "fp");
    rv = 2'b00;
    @(negedge clk);
    check("fp_cnt", cnt, 32'd4);
    @(posedge clk);
    #1;
    rv = 2'b10;
    step(2'b10, 32'd7, 32'hFFFFFFFF, "fp_p1");
    idle(2);

    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    rv = 2'b11;
    for (int i = 0; i < 20; i++) step(2'b01, 32'd7, 32'hFFFFFFFF, "sat");
    rv = 2'b00;
    @(negedge clk);
    check("sat_cnt", cnt, 32'd15);
    @(posedge clk);
    #1;
    rv = 2'b11;
    step(2'b01, 32'd7, 32'hFFFFFFFF, "sat_more");
    step(2'b01, 32'd7, 32'hFFFFFFFF, "sat_more");
    idle(3);
    check("sat_hold", cnt, 32'd15);
    check("qb0_empty", q0.size(), 32'h0);
    check("qb1_empty", q1.size(), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
